dpram_arbiter: RTL and testbench
================================

Name: dpram_arbiter

Overview:
- Two-client round-robin arbiter and sequencer in front of dual_port_ram (8-bit x 16 default).
- Shares the RAM write port between two write clients and the RAM read port between two read clients.
- Uses a req/gnt handshake and returns read data tagged per client.
- Forwards write data on a same-cycle read/write address collision, so reads never see an undefined value.

Parameters:
- RAM_WIDTH, 8, data word width (matches ram_width of the RAM).
- ADDR_SIZE, 4, address width.
- RAM_DEPTH, 16, number of words (2**ADDR_SIZE).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_req  input  2  write request, bit i = client i.
- wr_addr  input  2*ADDR_SIZE  client i address at [i*ADDR_SIZE +: ADDR_SIZE].
- wr_data  input  2*RAM_WIDTH  client i data at [i*RAM_WIDTH +: RAM_WIDTH].
- wr_gnt  output  2  one-hot write grant (combinational).
- rd_req  input  2  read request per client.
- rd_addr  input  2*ADDR_SIZE  client i read address.
- rd_gnt  output  2  one-hot read grant (combinational).
- rd_valid  output  2  one-hot; bit i high = rd_data belongs to client i.
- rd_data  output  RAM_WIDTH  returned read data.
- ram_write_en  output  1  to RAM write_en.
- ram_wr_addr  output  ADDR_SIZE  to RAM wr_addr.
- ram_data_in  output  RAM_WIDTH  to RAM data_in.
- ram_read_en  output  1  to RAM read_en.
- ram_rd_addr  output  ADDR_SIZE  to RAM rd_addr.
- ram_data_out  input  RAM_WIDTH  from RAM data_out; valid the cycle after read_en is sampled.

Behaviour:
- Reset (reset=0, async):
  - wr_ptr=0, rd_ptr=0, rd_valid=0, fwd_flag=0, fwd_data=0.
  - While reset=0, wr_gnt=0, rd_gnt=0, ram_write_en=0, ram_read_en=0.
  - An in-flight read is dropped: no rd_valid after reset releases.
- Handshake:
  - A client holds req, addr and data stable until it sees gnt.
  - A transfer occurs in the cycle where req&gnt=1.
  - Dropping req before gnt is legal (request withdrawn).
- Grant (independent per port): grants are combinational from req and the port's pointer.
  - Only one requester: it is granted.
  - Both requesting: the client equal to ptr wins.
  - After any grant to client k, ptr <= ~k on the clock edge.
  - Result: strict alternation under continuous contention, and a client waits at most one grant.
- Write path: ram_write_en = |wr_gnt; ram_wr_addr and ram_data_in are muxed from the granted client. Zero added latency.
- Read path:
  - ram_read_en = |rd_gnt; ram_rd_addr is muxed from the granted client.
  - Next cycle: rd_valid = registered rd_gnt, and rd_data = fwd_flag ? fwd_data : ram_data_out.
  - Read latency from grant to data is 1 cycle. Back-to-back reads every cycle are supported.
- Collision: a write grant and read grant in the same cycle with equal addresses sets fwd_flag=1 and fwd_data=granted write data. The read returns the new data.
- rd_data when rd_valid=0 is don't-care; the bench must not check it.
- No internal state beyond ptrs, the valid register and the forward registers. There is no FIFO; the RAM contents are the only storage.

Decomposition:
- Shared package dpram_pkg: RAM_WIDTH, ADDR_SIZE and RAM_DEPTH defaults, plus the client-count constant NUM_CLIENTS=2.
- One natural sub-module, rr_arb2: a 2-way round-robin arbiter (req[1:0], ptr register, gnt[1:0]), instantiated twice (write port, read port).
- The forward/valid logic stays in dpram_arbiter.

Test Plan:
- Reset: reset=0 mid-sequence with rd_req=2'b01 granted the previous cycle -> rd_valid=0 after release; wr_ptr=rd_ptr=0; first contended grant goes to client 0.
- Single writer: client 0 writes addr 0..15 with data i+1; then client 1 reads addr 0..15 -> rd_valid=2'b10 and rd_data=i+1, each one cycle after grant.
- Write contention: wr_req=2'b11 held 6 cycles, distinct addrs -> wr_gnt sequence 01,10,01,10,01,10; RAM holds all 6 words.
- Read contention: both clients read addr 3 (preloaded 8'hA5) continuously -> rd_valid alternates 01/10 every cycle and rd_data=8'hA5 each cycle.
- Collision: addr 7 holds 8'h11; same cycle write 8'h5A to addr 7 and read addr 7 -> next cycle rd_data=8'h5A; a later read of addr 7 returns 8'h5A.
- Withdrawal: client 1 raises rd_req for 1 cycle while client 0 holds priority, then drops it -> no rd_valid for client 1; rd_ptr changes only on actual grants.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared sizing constants for the dual-port RAM front end.
package dpram_pkg;
  localparam int RAM_WIDTH   = 8;
  localparam int ADDR_SIZE   = 4;
  localparam int RAM_DEPTH   = 16;
  localparam int NUM_CLIENTS = 2;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; under contention
// the client named by the pointer wins, then the pointer moves to the other one.
module rr_arb2 import dpram_pkg::*; (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic [NUM_CLIENTS-1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant decode and pointer advance; grants are held low while in reset
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (reset) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin sequencer sharing one RAM write port and one RAM read port
// between two clients each, with write-to-read forwarding on address collision.
module dpram_arbiter import dpram_pkg::*; #(
  parameter int RAM_WIDTH = dpram_pkg::RAM_WIDTH,
  parameter int ADDR_SIZE = dpram_pkg::ADDR_SIZE,
  parameter int RAM_DEPTH = dpram_pkg::RAM_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           wr_req,
  input  logic [NUM_CLIENTS*ADDR_SIZE-1:0] wr_addr,
  input  logic [NUM_CLIENTS*RAM_WIDTH-1:0] wr_data,
  output logic [NUM_CLIENTS-1:0]           wr_gnt,
  input  logic [NUM_CLIENTS-1:0]           rd_req,
  input  logic [NUM_CLIENTS*ADDR_SIZE-1:0] rd_addr,
  output logic [NUM_CLIENTS-1:0]           rd_gnt,
  output logic [NUM_CLIENTS-1:0]           rd_valid,
  output logic [RAM_WIDTH-1:0]             rd_data,
  output logic                             ram_write_en,
  output logic [ADDR_SIZE-1:0]             ram_wr_addr,
  output logic [RAM_WIDTH-1:0]             ram_data_in,
  output logic                             ram_read_en,
  output logic [ADDR_SIZE-1:0]             ram_rd_addr,
  input  logic [RAM_WIDTH-1:0]             ram_data_out
);

  if (RAM_DEPTH != (1 << ADDR_SIZE)) begin : g_depth_check
    $error("dpram_arbiter: RAM_DEPTH must equal 2**ADDR_SIZE");
  end

  logic [NUM_CLIENTS-1:0] rd_valid_q, rd_valid_d;
  logic                   fwd_flag_q, fwd_flag_d;
  logic [RAM_WIDTH-1:0]   fwd_data_q, fwd_data_d;

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wr_req),
    .gnt   (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .req   (rd_req),
    .gnt   (rd_gnt)
  );

  // Steer the granted client's address and data onto the RAM ports
  always_comb begin
    ram_write_en = |wr_gnt;
    ram_read_en  = |rd_gnt;
    ram_wr_addr  = wr_gnt[1] ? wr_addr[ADDR_SIZE +: ADDR_SIZE] : wr_addr[0 +: ADDR_SIZE];
    ram_data_in  = wr_gnt[1] ? wr_data[RAM_WIDTH +: RAM_WIDTH] : wr_data[0 +: RAM_WIDTH];
    ram_rd_addr  = rd_gnt[1] ? rd_addr[ADDR_SIZE +: ADDR_SIZE] : rd_addr[0 +: ADDR_SIZE];
  end

  // Next-state for read tagging and forwarding of a same-address write
  always_comb begin
    rd_valid_d = rd_gnt;
    fwd_flag_d = ram_write_en && ram_read_en && (ram_wr_addr == ram_rd_addr);
    fwd_data_d = fwd_flag_d ? ram_data_in : fwd_data_q;
  end

  // Read-return registers; reset drops any read still in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= '0;
      fwd_flag_q <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      fwd_flag_q <= fwd_flag_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Returned data: forwarded write word on collision, RAM output otherwise
  always_comb begin
    rd_valid = rd_valid_q;
    rd_data  = fwd_flag_q ? fwd_data_q : ram_data_out;
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: behavioural RAM, directed scenarios and random traffic
// compared against a transaction-level model of grants, memory and read returns.
module tb_dpram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
  logic [2*AW-1:0] wr_addr, rd_addr;
  logic [2*DW-1:0] wr_data;
  logic [DW-1:0]   rd_data, ram_data_in;
  logic [DW-1:0]   ram_data_out = '0;
  logic            ram_write_en, ram_read_en;
  logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]   ram [16] = '{default: '0};

  dpram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .ram_write_en (ram_write_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_read_en  (ram_read_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_out (ram_data_out)
  );

  // Simple synchronous dual-port RAM, read-before-write on a shared address
  always @(posedge clk) begin
    if (ram_write_en) ram[ram_wr_addr] <= ram_data_in;
    if (ram_read_en)  ram_data_out <= ram[ram_rd_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: memory image, per-port priority client, pending return
  logic [DW-1:0] m_mem [16] = '{default: '0};
  int            m_wprio = 0;
  int            m_rprio = 0;
  logic [1:0]    m_vld = 2'b00;
  logic [DW-1:0] m_data = '0;
  logic [1:0]    last_wg = 2'b00;
  logic [1:0]    last_rg = 2'b00;

  function automatic logic [1:0] pick(input logic [1:0] req, input int prio);
    if (req == 2'b11) return (prio == 0) ? 2'b01 : 2'b10;
    return req;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_wr(input int c, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req[c] = en;
    wr_addr[c*AW +: AW] = a;
    wr_data[c*DW +: DW] = d;
  endtask

  task automatic set_rd(input int c, input logic en, input logic [AW-1:0] a);
    rd_req[c] = en;
    rd_addr[c*AW +: AW] = a;
  endtask

  // One clock: inputs already driven after a falling edge; check, advance model
  task automatic step();
    logic [1:0]    eg, rg;
    int            wc, rc;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    #1;
    eg = reset ? pick(wr_req, m_wprio) : 2'b00;
    rg = reset ? pick(rd_req, m_rprio) : 2'b00;
    chk("wr_gnt", {30'b0, wr_gnt}, {30'b0, eg});
    chk("rd_gnt", {30'b0, rd_gnt}, {30'b0, rg});
    chk("ram_write_en", {31'b0, ram_write_en}, {31'b0, (eg != 2'b00)});
    chk("ram_read_en", {31'b0, ram_read_en}, {31'b0, (rg != 2'b00)});
    chk("rd_valid", {30'b0, rd_valid}, {30'b0, (reset ? m_vld : 2'b00)});
    if (reset && m_vld != 2'b00) chk("rd_data", {24'b0, rd_data}, {24'b0, m_data});
    wc = eg[1] ? 1 : 0;
    rc = rg[1] ? 1 : 0;
    wa = wr_addr[wc*AW +: AW];
    wd = wr_data[wc*DW +: DW];
    ra = rd_addr[rc*AW +: AW];
    if (eg != 2'b00) begin
      chk("ram_wr_addr", {28'b0, ram_wr_addr}, {28'b0, wa});
      chk("ram_data_in", {24'b0, ram_data_in}, {24'b0, wd});
    end
    if (rg != 2'b00) chk("ram_rd_addr", {28'b0, ram_rd_addr}, {28'b0, ra});
    if (!reset) begin
      m_wprio = 0;
      m_rprio = 0;
      m_vld   = 2'b00;
    end else begin
      m_vld = rg;
      if (rg != 2'b00) m_data = (eg != 2'b00 && wa == ra) ? wd : m_mem[ra];
      if (eg != 2'b00) begin
        m_mem[wa] = wd;
        m_wprio   = 1 - wc;
      end
      if (rg != 2'b00) m_rprio = 1 - rc;
    end
    last_wg = eg;
    last_rg = rg;
    @(negedge clk);
  endtask

  task automatic clear_all();
    wr_req = '0; wr_addr = '0; wr_data = '0;
    rd_req = '0; rd_addr = '0;
  endtask

  initial begin
    int i0, i1;
    clear_all();
    @(negedge clk);
    step();
    step();
    reset = 1'b1;
    step();

    // Single writer fills memory, then the other client reads it back
    for (int i = 0; i < 16; i++) begin
      set_wr(0, 1'b1, 4'(i), 8'(i + 1));
      step();
    end
    set_wr(0, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      set_rd(1, 1'b1, 4'(i));
      step();
    end
    set_rd(1, 1'b0, '0);
    step();

    // Both readers hammer the same preloaded word
    set_wr(0, 1'b1, 4'd3, 8'hA5);
    step();
    set_wr(0, 1'b0, '0, '0);
    set_rd(0, 1'b1, 4'd3);
    set_rd(1, 1'b1, 4'd3);
    repeat (6) step();
    clear_all();
    step();

    // Same-cycle write and read to one address
    set_wr(0, 1'b1, 4'd7, 8'h11);
    step();
    set_wr(0, 1'b0, '0, '0);
    set_wr(1, 1'b1, 4'd7, 8'h5A);
    set_rd(0, 1'b1, 4'd7);
    step();
    set_wr(1, 1'b0, '0, '0);
    step();
    set_rd(0, 1'b0, '0);
    step();

    // Withdrawn request must not move the pointer or return data
    set_rd(1, 1'b1, 4'd2);
    step();
    set_rd(0, 1'b1, 4'd4);
    set_rd(1, 1'b1, 4'd9);
    step();
    clear_all();
    step();
    step();
    set_rd(0, 1'b1, 4'd4);
    set_rd(1, 1'b1, 4'd9);
    #1 chk("wd_ptr", {30'b0, rd_gnt}, 32'h2);
    step();
    clear_all();
    step();

    // Reset while a read is in flight, with contending writers waiting
    set_rd(0, 1'b1, 4'd5);
    step();
    reset = 1'b0;
    set_rd(0, 1'b0, '0);
    set_wr(0, 1'b1, 4'd8, 8'h48);
    set_wr(1, 1'b1, 4'd9, 8'h49);
    step();
    step();
    reset = 1'b1;
    #1 chk("rst_vld", {30'b0, rd_valid}, 32'h0);

    // Write contention: strict alternation starting from client 0
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 6; k++) begin
      #1 chk("wc_seq", {30'b0, wr_gnt}, (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      if (last_wg[0]) i0++;
      if (last_wg[1]) i1++;
      set_wr(0, (i0 < 3), 4'(8 + 2*i0), 8'(8'h48 + 2*i0));
      set_wr(1, (i1 < 3), 4'(9 + 2*i1), 8'(8'h49 + 2*i1));
    end
    clear_all();
    for (int a = 8; a < 14; a++) begin
      set_rd(0, 1'b1, 4'(a));
      step();
    end
    clear_all();
    step();

    // Random traffic obeying hold-until-grant, with occasional withdrawal
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!wr_req[c] || last_wg[c]) begin
          set_wr(c, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end else if ($urandom_range(0, 19) == 0) begin
          wr_req[c] = 1'b0;
        end
        if (!rd_req[c] || last_rg[c]) begin
          set_rd(c, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end else if ($urandom_range(0, 19) == 0) begin
          rd_req[c] = 1'b0;
        end
      end
      step();
    end
    clear_all();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
